// File: rtl/nibble_operand_assembler_pkg.sv
// Shared constants and FSM encoding for the nibble operand assembler.
// NIBBLE_W and OPC_WIDTH are also used by the ALU core.
package nibble_operand_assembler_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int OPC_WIDTH = 4;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        PRESENT = 2'd3
    } asm_state_e;

endpackage

// File: rtl/nibble_operand_assembler_shift_reg.sv
// nibble_shift_reg: LSB-first nibble shifter, one per operand.
// Ports: clock, reset_n (async low), shift_en, nib_in[3:0], q[W-1:0].
module nibble_shift_reg
    import nibble_operand_assembler_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                shift_en,
    input  logic [NIBBLE_W-1:0] nib_in,
    output logic [W-1:0]        q
);

    logic [W-1:0] r_q;

    // New nibble enters at the top so the first one ends up in bits [3:0].
    generate
        if (NIBBLES == 1) begin : g_one
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    r_q <= '0;
                else if (shift_en)
                    r_q <= nib_in;
            end
        end else begin : g_multi
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    r_q <= '0;
                else if (shift_en)
                    r_q <= {nib_in, r_q[W-1:NIBBLE_W]};
            end
        end
    endgenerate

    assign q = r_q;

endmodule

// File: rtl/nibble_operand_assembler.sv
// Serial-to-parallel ALU front end: nibble stream -> op_a, op_b, opcode,
// presented with op_valid/op_ready. Inputs: clock, reset_n (async low),
// nib_in/nib_valid, flush, op_ready. Outputs: nib_ready, op_a, op_b,
// opcode, op_valid, busy. Define NIBBLE_ASM_OPCOUNT_EN to add op_count[7:0].
module nibble_operand_assembler
    import nibble_operand_assembler_pkg::*;
#(
    parameter  int NIBBLES = 4,
    parameter  int OPC_W   = OPC_WIDTH,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NIBBLE_W-1:0] nib_in,
    input  logic                nib_valid,
    output logic                nib_ready,
    input  logic                flush,
    output logic [W-1:0]        op_a,
    output logic [W-1:0]        op_b,
    output logic [OPC_W-1:0]    opcode,
    output logic                op_valid,
    input  logic                op_ready,
`ifdef NIBBLE_ASM_OPCOUNT_EN
    output logic [7:0]          op_count,
`endif
    output logic                busy
);

    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    generate
        if (OPC_W != NIBBLE_W || NIBBLES < 1 || NIBBLES > 8) begin : g_bad_cfg
            $error("nibble_operand_assembler: illegal OPC_W or NIBBLES");
        end
    endgenerate

    asm_state_e        r_state;
    logic [CNT_W-1:0]  r_nib_cnt;
    logic [OPC_W-1:0]  r_opcode;
    logic              r_op_valid;

    logic w_accept;
    logic w_shift_a;
    logic w_shift_b;
    logic w_handshake;

    // Flush drops any nibble offered in the same cycle.
    assign w_accept    = nib_valid && nib_ready && !flush;
    assign w_shift_a   = w_accept && (r_state == LOAD_A);
    assign w_shift_b   = w_accept && (r_state == LOAD_B);
    assign w_handshake = r_op_valid && op_ready;

    nibble_shift_reg #(.NIBBLES(NIBBLES)) u_sr_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (w_shift_a),
        .nib_in   (nib_in),
        .q        (op_a)
    );

    nibble_shift_reg #(.NIBBLES(NIBBLES)) u_sr_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (w_shift_b),
        .nib_in   (nib_in),
        .q        (op_b)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= LOAD_A;
            r_nib_cnt  <= '0;
            r_opcode   <= '0;
            r_op_valid <= 1'b0;
        end else if (flush) begin
            r_state    <= LOAD_A;
            r_nib_cnt  <= '0;
            r_op_valid <= 1'b0;
        end else begin
            unique case (r_state)
                LOAD_A: begin
                    if (w_accept) begin
                        if (r_nib_cnt == LAST) begin
                            r_state   <= LOAD_B;
                            r_nib_cnt <= '0;
                        end else begin
                            r_nib_cnt <= r_nib_cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        if (r_nib_cnt == LAST) begin
                            r_state   <= LOAD_OP;
                            r_nib_cnt <= '0;
                        end else begin
                            r_nib_cnt <= r_nib_cnt + 1'b1;
                        end
                    end
                end
                LOAD_OP: begin
                    if (w_accept) begin
                        r_opcode   <= nib_in[OPC_W-1:0];
                        r_state    <= PRESENT;
                        r_op_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (w_handshake) begin
                        r_state    <= LOAD_A;
                        r_op_valid <= 1'b0;
                    end
                end
                default: r_state <= LOAD_A;
            endcase
        end
    end

`ifdef NIBBLE_ASM_OPCOUNT_EN
    logic [7:0] r_op_count;

    // Counts every consumed operation, flush-coincident ones included.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_op_count <= '0;
        else if (w_handshake)
            r_op_count <= r_op_count + 8'd1;
    end

    assign op_count = r_op_count;
`endif

    // Ready depends on state only, never on op_ready.
    assign nib_ready = (r_state != PRESENT);
    assign busy      = (r_nib_cnt != '0) || (r_state == LOAD_B) ||
                       (r_state == LOAD_OP);
    assign opcode    = r_opcode;
    assign op_valid  = r_op_valid;

endmodule

// File: tb/tb_nibble_operand_assembler.sv
// Scoreboard bench for nibble_operand_assembler (NIBBLES=4).
// Stimulus pushes expected ops; a negedge monitor pops on each handshake.
module tb_nibble_operand_assembler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        nib_ready;
    logic        flush;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  opcode;
    logic        op_valid;
    logic        op_ready;
    logic        busy;
`ifdef NIBBLE_ASM_OPCOUNT_EN
    logic [7:0]  op_count;
`endif

    always #5 clock = ~clock;

    nibble_operand_assembler #(.NIBBLES(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .nib_in    (nib_in),
        .nib_valid (nib_valid),
        .nib_ready (nib_ready),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .opcode    (opcode),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
`ifdef NIBBLE_ASM_OPCOUNT_EN
        .op_count  (op_count),
`endif
        .busy      (busy)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  opc;
    } op_t;

    op_t exp_q[$];
    op_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_ops   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_op: got a=%h b=%h opc=%h want none",
                         op_a, op_b, opcode);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_op_a", {16'h0, op_a}, {16'h0, mon_e.a});
                check("sb_op_b", {16'h0, op_b}, {16'h0, mon_e.b});
                check("sb_opcode", {28'h0, opcode}, {28'h0, mon_e.opc});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        nib_in    = n;
        nib_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (nib_ready) break;
        end
        if (!nib_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL nib_timeout: got ready=%b want 1", nib_ready);
        end
        @(posedge clock);
        #1;
        nib_valid = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] opc, input int gap);
        exp_q.push_back('{a: a, b: b, opc: opc});
        n_ops++;
        for (int i = 0; i < 4; i++) begin
            send_nib(a[4*i +: 4]);
            idle(gap);
        end
        for (int i = 0; i < 4; i++) begin
            send_nib(b[4*i +: 4]);
            idle(gap);
        end
        send_nib(opc);
    endtask

    initial begin
        reset_n   = 1'b0;
        nib_in    = 4'h0;
        nib_valid = 1'b0;
        flush     = 1'b0;
        op_ready  = 1'b1;
        #12;
        reset_n = 1'b1;
        #1;

        // reset state
        @(negedge clock);
        check("rst_op_valid", {31'h0, op_valid}, 32'd0);
        check("rst_nib_ready", {31'h0, nib_ready}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_op_a", {16'h0, op_a}, 32'd0);
        check("rst_op_b", {16'h0, op_b}, 32'd0);
        check("rst_opcode", {28'h0, opcode}, 32'd0);
        @(posedge clock);
        #1;

        // basic op, op_ready=1
        send_op(16'h1234, 16'h00FF, 4'h5, 0);
        @(negedge clock);
        check("lat_op_valid", {31'h0, op_valid}, 32'd1);
        check("lat_nib_ready", {31'h0, nib_ready}, 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("post_op_valid", {31'h0, op_valid}, 32'd0);
        check("post_nib_ready", {31'h0, nib_ready}, 32'd1);
        @(posedge clock);
        #1;

        // backpressure, plus a next-op nibble that must be refused
        op_ready = 1'b0;
        send_op(16'h1234, 16'h00FF, 4'h5, 0);
        nib_in    = 4'h7;
        nib_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            check("bp_op_valid", {31'h0, op_valid}, 32'd1);
            check("bp_nib_ready", {31'h0, nib_ready}, 32'd0);
            check("bp_op_a", {16'h0, op_a}, 32'h1234);
            check("bp_op_b", {16'h0, op_b}, 32'h00FF);
            check("bp_opcode", {28'h0, opcode}, 32'h5);
            @(posedge clock);
            #1;
        end
        nib_valid = 1'b0;
        op_ready  = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("bp_after_busy", {31'h0, busy}, 32'd0);
        check("bp_after_valid", {31'h0, op_valid}, 32'd0);
        @(posedge clock);
        #1;

        // bubbles between nibbles
        send_op(16'h1234, 16'h00FF, 4'h5, 1);
        idle(3);

        // flush mid-LOAD_B with a dropped nibble
        send_nib(4'h4);
        send_nib(4'h3);
        send_nib(4'h2);
        send_nib(4'h1);
        send_nib(4'hF);
        send_nib(4'hF);
        @(negedge clock);
        check("pre_flush_busy", {31'h0, busy}, 32'd1);
        flush     = 1'b1;
        nib_in    = 4'h9;
        nib_valid = 1'b1;
        @(posedge clock);
        #1;
        flush     = 1'b0;
        nib_valid = 1'b0;
        @(negedge clock);
        check("flush_busy", {31'h0, busy}, 32'd0);
        check("flush_valid", {31'h0, op_valid}, 32'd0);
        check("flush_ready", {31'h0, nib_ready}, 32'd1);
        @(posedge clock);
        #1;
        send_op(16'h000A, 16'h0003, 4'h1, 0);
        idle(3);

        // asynchronous reset mid-LOAD_B
        send_nib(4'hD);
        send_nib(4'hC);
        send_nib(4'hB);
        send_nib(4'hA);
        send_nib(4'h6);
        send_nib(4'h6);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_op_a", {16'h0, op_a}, 32'd0);
        check("arst_op_b", {16'h0, op_b}, 32'd0);
        check("arst_busy", {31'h0, busy}, 32'd0);
        check("arst_ready", {31'h0, nib_ready}, 32'd1);
        #10;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send_op(16'hABCD, 16'h1357, 4'h9, 0);
        idle(3);

`ifdef NIBBLE_ASM_OPCOUNT_EN
        check("cnt_mid", {24'h0, op_count}, 32'd1);
        for (int i = 0; i < 257; i++)
            send_op(16'(i), 16'(i * 3), 4'(i), 0);
        idle(3);
        check("cnt_wrap", {24'h0, op_count}, 32'd2);
`endif

        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clock);
        end
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
